// File: rtl/mmio_initiator.sv
// MMIO initiator: a posted-write FIFO in front of a single outstanding blocking read.
// Defining MMIO_TIMEOUT_EN adds a read timeout that returns an error response.
module mmio_initiator #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rerr,
    output logic        busy,
    output logic        wready,
    input  logic        wvalid,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        rready,
    input  logic        rvalid,
    output logic [31:0] raddr,
    input  logic        rresp,
    input  logic [31:0] rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mmio_initiator: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mmio_initiator: TIMEOUT_CYCLES must fit in 8 bits and be non-zero");
    end

    typedef enum logic [1:0] {
        IDLE,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [3:0]    fifo_strb [FIFO_DEPTH];
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          rd_accept;
    logic          rd_done;
    logic          rd_timeout;

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

    // Reads are only taken once every posted write has drained, so they never overtake one.
    assign cpu_ack   = cpu_req & (cpu_we ? ~fifo_full : (fifo_empty & (state == IDLE)));
    assign push      = cpu_ack & cpu_we;
    assign rd_accept = cpu_ack & ~cpu_we;
    assign pop       = wready & wvalid;
    assign rd_done   = (state == RD_DATA) & rresp;
    assign busy      = ~fifo_empty | (state != IDLE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_idx] <= cpu_addr;
            fifo_data[wr_idx] <= cpu_wdata;
            fifo_strb[wr_idx] <= cpu_wstrb;
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] tmo_cnt;
    logic       rerr_q;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tmo_cnt <= '0;
        end else if (rd_accept) begin
            tmo_cnt <= '0;
        end else if (state != IDLE) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // A response arriving on the limit cycle wins over the timeout.
    assign rd_timeout = (state != IDLE) && (tmo_cnt == TMO_LIMIT) && !rd_done;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rerr_q <= 1'b0;
        end else begin
            rerr_q <= rd_timeout;
        end
    end

    assign cpu_rerr = rerr_q;
`else
    assign rd_timeout = 1'b0;
    assign cpu_rerr   = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_accept) state_nxt = RD_ADDR;
            end
            RD_ADDR: begin
                if (rd_timeout)  state_nxt = IDLE;
                else if (rvalid) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                if (rd_done || rd_timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wready = 1'b0;
        rready = 1'b0;
        waddr  = '0;
        wdata  = '0;
        wstrb  = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    wready = 1'b1;
                    waddr  = fifo_addr[rd_idx];
                    wdata  = fifo_data[rd_idx];
                    wstrb  = fifo_strb[rd_idx];
                end
            end
            RD_ADDR: rready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            raddr <= '0;
        end else if (rd_accept) begin
            raddr <= cpu_addr;
        end
    end

    // cpu_rdata only changes on a read return, so it holds between reads.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            cpu_rvalid <= rd_done | rd_timeout;
            if (rd_done) begin
                cpu_rdata <= rdata;
            end else if (rd_timeout) begin
                cpu_rdata <= '0;
            end
        end
    end

endmodule

// File: doc/mmio_initiator.md
MMIO_INITIATOR -- requirements
Module: mmio_initiator

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, posted-write buffer entries (power of 2, >=2); TIMEOUT_CYCLES, default 255, read timeout limit (8-bit).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  clock.
- resetb  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  core request.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  byte strobes.
- cpu_ack  out  1  request accepted this cycle.
- cpu_rvalid  out  1  read-return pulse.
- cpu_rdata  out  32  read data.
- cpu_rerr  out  1  read error, qualified by cpu_rvalid.
- busy  out  1  FIFO non-empty or read in flight.
- wready  out  1  write request to peripheral.
- wvalid  in  1  peripheral accepts write.
- waddr  out  32  write address.
- wdata  out  32  write data.
- wstrb  out  4  write strobes.
- rready  out  1  read request to peripheral.
- rvalid  in  1  peripheral accepts read address.
- raddr  out  32  read address.
- rresp  in  1  read data valid.
- rdata  in  32  read data.

Function
REQ-003 cpu_ack SHALL be combinational: cpu_req & (cpu_we ? FIFO not full : (FIFO empty & state==IDLE)).
- A write accepted while the FIFO is full-and-popping SHALL NOT be possible; full blocks acceptance regardless of a same-cycle pop.
REQ-004 Each accepted write SHALL push {addr, wdata, wstrb} into the FIFO. Writes SHALL be posted: no completion is returned to the core.
REQ-005 Whenever the FIFO is non-empty and state==IDLE, wready SHALL be 1, with waddr/wdata/wstrb driven from the FIFO head.
- The head SHALL pop on any cycle with wready & wvalid.
- Writes SHALL drain in strict push order.
- The pointers SHALL wrap modulo FIFO_DEPTH.
- The full/empty distinction SHALL use one extra pointer bit.
REQ-006 The state machine SHALL have three states: IDLE, RD_ADDR, RD_DATA.
- IDLE -> RD_ADDR on an accepted read; cpu_addr is latched into raddr.
- RD_ADDR drives rready=1 and holds raddr; RD_ADDR -> RD_DATA on rvalid=1.
- RD_DATA keeps rready=0. On rresp=1: rdata is registered into cpu_rdata, cpu_rvalid=1 with cpu_rerr=0 on the following cycle, and the FSM returns to IDLE.
REQ-007 Read latency with a zero-wait peripheral SHALL be as follows (accept at cycle 0):
- rready=1 at cycle 1.
- rresp sampled at cycle 2.
- cpu_rvalid=1 at cycle 3 for exactly one cycle.
REQ-008 wready and rready SHALL never be 1 in the same cycle. Reads SHALL NOT bypass buffered writes.
REQ-009 cpu_rdata SHALL hold its last value until the next read return.
REQ-010 busy SHALL be (FIFO non-empty) | (state!=IDLE).

Reset
REQ-011 On resetb low, the block SHALL asynchronously reset the following to 0: FIFO pointers, wready, rready, waddr, wdata, wstrb, raddr, cpu_rvalid, cpu_rdata, cpu_rerr, the timeout counter, and busy. The state SHALL reset to IDLE.
REQ-012 A reset during RD_ADDR/RD_DATA or with buffered writes SHALL discard them without any cpu_rvalid pulse. A late rresp after reset SHALL be ignored.

Configuration
REQ-013 With MMIO_TIMEOUT_EN defined, an 8-bit counter SHALL operate as follows:
- It clears on entry to RD_ADDR and increments each cycle in RD_ADDR/RD_DATA.
- When it reaches TIMEOUT_CYCLES without completion, the FSM SHALL return to IDLE with cpu_rvalid=1, cpu_rerr=1, cpu_rdata=32'h0 the next cycle.
- A subsequent stray rresp in IDLE SHALL be ignored.
REQ-014 Without MMIO_TIMEOUT_EN, no counter SHALL exist, reads SHALL wait indefinitely, and cpu_rerr SHALL be tied to 0.

Verification
REQ-015 Single read, peripheral returns 32'h1234_5678 one cycle after rready: accept cycle 0 -> cpu_rvalid at cycle 3, cpu_rdata=32'h1234_5678, cpu_rerr=0.
REQ-016 Five back-to-back writes with wvalid held 0: first four acked, fifth cpu_ack=0 -> wvalid=1 -> writes appear on waddr in push order, and the fifth is acked on the cycle after the first pop.
REQ-017 Write to 0x0200_4000 then read of 0x0200_BFF8 in consecutive cycles -> read not acked until the write pops; wready and rready never high together.
REQ-018 MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=8, rvalid=1 but rresp held 0 -> cpu_rvalid=1, cpu_rerr=1, cpu_rdata=0 at the timeout point; a later rresp causes no extra pulse.
REQ-019 resetb asserted while in RD_DATA with two writes buffered -> all outputs 0, state IDLE, no cpu_rvalid; the following read completes normally.
